// File: rtl/rsa_two_power_mod.sv
// rsa_two_power_mod
// Pre-conditioning stage that sits in front of the Montgomery exponentiator.
// It takes one raw job {msg, key, modulus} and computes the Montgomery
// conversion constant base = 2^(2*MOD_WIDTH) mod modulus. The constant is
// built by repeated doubling with one conditional subtract per cycle,
// starting from r = 1. The block then presents the packed job
// {base, msg, key, modulus} on a valid/ready output.
// Only one job is in flight at a time.

module rsa_two_power_mod #(
    parameter int MOD_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [MOD_WIDTH-1:0]   i_msg,
    input  logic [MOD_WIDTH-1:0]   i_key,
    input  logic [MOD_WIDTH-1:0]   i_modulus,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [4*MOD_WIDTH-1:0] o_out
);

    // The counter must hold values 0 .. 2*MOD_WIDTH.
    localparam int CNT_W = $clog2(2*MOD_WIDTH+1);
    // This is the counter value on the last doubling step.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2*MOD_WIDTH-1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_reg,   state_next;
    logic [CNT_W-1:0]       counter_reg, counter_next;
    logic [MOD_WIDTH-1:0]   r_reg,       r_next;
    logic [MOD_WIDTH-1:0]   msg_reg,     msg_next;
    logic [MOD_WIDTH-1:0]   key_reg,     key_next;
    logic [MOD_WIDTH-1:0]   mod_reg,     mod_next;

    // Datapath for one doubling step.
    logic [MOD_WIDTH:0]     shifted;
    logic [MOD_WIDTH-1:0]   diff;
    logic [MOD_WIDTH-1:0]   step_r;

    logic                   accept;

    // The block accepts a job only in IDLE. Reset masks this so that no
    // upstream handshake can appear to complete while reset is held.
    assign i_ready = (state_reg == ST_IDLE) && !rst;
    assign accept  = i_valid && i_ready;
    assign o_valid = (state_reg == ST_DONE);

    // One shift-and-subtract step. The compare uses the full MOD_WIDTH+1-bit
    // doubled value, so a carry out of the top bit is never lost. The
    // subtraction only needs the low bits: when t >= N the true result is
    // below N and therefore fits in MOD_WIDTH bits.
    always_comb begin
        shifted = {r_reg, 1'b0};
        diff    = shifted[MOD_WIDTH-1:0] - mod_reg;
        step_r  = (shifted >= {1'b0, mod_reg}) ? diff : shifted[MOD_WIDTH-1:0];
    end

    // This block holds the state register and the captured job registers.
    // Reset takes priority over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            r_reg       <= '0;
            msg_reg     <= '0;
            key_reg     <= '0;
            mod_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            r_reg       <= r_next;
            msg_reg     <= msg_next;
            key_reg     <= key_next;
            mod_reg     <= mod_next;
        end
    end

    // This block computes the next state and the next register values. By
    // default every register holds its value, so the job registers and r
    // stay frozen while DONE waits for the output handshake.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        r_next       = r_reg;
        msg_next     = msg_reg;
        key_next     = key_reg;
        mod_next     = mod_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    msg_next     = i_msg;
                    key_next     = i_key;
                    mod_next     = i_modulus;
                    // The residue of 1 mod 1 is 0. Every later doubling of 0
                    // also stays 0, so starting from 0 gives the result 0.
                    r_next       = (i_modulus == MOD_WIDTH'(1)) ? '0 : MOD_WIDTH'(1);
                    counter_next = '0;
                    state_next   = ST_CALC;
                end
            end
            ST_CALC: begin
                r_next       = step_r;
                counter_next = counter_reg + CNT_ONE;
                if (counter_reg == LAST_STEP) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (o_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The output word is {base, msg, key, modulus} with base in the top
    // field. Each field is placed into its own MOD_WIDTH slice.
    logic [MOD_WIDTH-1:0] out_field [4];

    assign out_field[0] = mod_reg;
    assign out_field[1] = key_reg;
    assign out_field[2] = msg_reg;
    assign out_field[3] = r_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign o_out[gi*MOD_WIDTH +: MOD_WIDTH] = out_field[gi];
        end
    endgenerate

endmodule

// File: tb/tb_rsa_two_power_mod.sv
// Testbench for rsa_two_power_mod.
// It runs a small instance with MOD_WIDTH=8 against a transaction-level
// model: each accepted job must produce 2^16 mod N after 17 cycles and
// hold until it is taken. A second instance with MOD_WIDTH=256 covers the
// wide datapath with a single directed job.

module tb_rsa_two_power_mod;

    localparam int W   = 8;
    localparam int LAT = 2*W + 1;
    localparam int BW  = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b1;

    // Small instance
    logic           i_valid = 1'b0;
    logic           i_ready;
    logic [W-1:0]   i_msg = '0;
    logic [W-1:0]   i_key = '0;
    logic [W-1:0]   i_modulus = '0;
    logic           o_valid;
    logic           o_ready = 1'b0;
    logic [4*W-1:0] o_out;

    // Wide instance
    logic            b_i_valid = 1'b0;
    logic            b_i_ready;
    logic [BW-1:0]   b_msg = '0;
    logic [BW-1:0]   b_key = '0;
    logic [BW-1:0]   b_mod = '0;
    logic            b_o_valid;
    logic            b_o_ready = 1'b1;
    logic [4*BW-1:0] b_o_out;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    rsa_two_power_mod #(.MOD_WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_msg     (i_msg),
        .i_key     (i_key),
        .i_modulus (i_modulus),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_out     (o_out)
    );

    rsa_two_power_mod #(.MOD_WIDTH(BW)) u_big (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (b_i_valid),
        .i_ready   (b_i_ready),
        .i_msg     (b_msg),
        .i_key     (b_key),
        .i_modulus (b_mod),
        .o_valid   (b_o_valid),
        .o_ready   (b_o_ready),
        .o_out     (b_o_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // The model value of 2^(2W) mod N. The base for N == 0 is a don't-care;
    // the model returns 0 so that the modulo operation is always defined.
    function automatic logic [7:0] model_base(input logic [7:0] n);
        if (n == 8'd0) return 8'd0;
        return 8'(32'h0001_0000 % {24'd0, n});
    endfunction

    // Transaction-level model. At most one job is outstanding. The job is
    // visible on the output from LAT cycles after it is accepted, and it
    // leaves on the first edge where the output is valid and o_ready is high.
    logic        m_busy = 1'b0;
    int          m_age  = 0;
    logic [31:0] m_out  = '0;
    logic        m_dc   = 1'b0;
    int          dut_acc[$];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (i_valid && i_ready) dut_acc.push_back(cycle);
        if (rst) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (i_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_out  <= {model_base(i_modulus), i_msg, i_key, i_modulus};
                m_dc   <= (i_modulus == 8'd0) || !i_modulus[0];
            end
        end else begin
            if (m_age >= LAT && o_ready) m_busy <= 1'b0;
            else                         m_age  <= m_age + 1;
        end
    end

    // Per-cycle check of every DUT output against the model. Outputs are
    // sampled on the falling edge, between the active clock edges.
    always @(negedge clk) begin
        if (cycle > 0) begin
            chk("i_ready", 256'(i_ready), 256'(!rst && !m_busy));
            chk("o_valid", 256'(o_valid), 256'(m_busy && m_age >= LAT));
            if (m_busy && m_age >= LAT) begin
                chk("o_out_job", 256'(o_out[23:0]), 256'(m_out[23:0]));
                if (!m_dc) chk("o_out_base", 256'(o_out[31:24]), 256'(m_out[31:24]));
            end
        end
    end

    // Run one job on the small instance. The task waits for i_ready, scrambles
    // the inputs after the accept edge, measures latency, and holds o_ready
    // low for 'stall' valid cycles before taking the result.
    task automatic do_job(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n,
                          input int stall, input logic use_lit, input logic [31:0] lit);
        int b;
        int lat;
        logic [31:0] got;
        b = 0;
        @(negedge clk);
        while (!i_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("wait_ready", 256'(i_ready), 256'(1));
        #1;
        i_valid = 1'b1; i_msg = m; i_key = k; i_modulus = n;
        o_ready = (stall == 0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_msg = 8'($urandom); i_key = 8'($urandom); i_modulus = 8'($urandom);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 256'(lat), 256'(LAT));
        got = o_out;
        if (use_lit) chk("literal_out", 256'(got), 256'(lit));
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 256'(o_valid), 256'(1));
            chk("stall_out", 256'(o_out), 256'(got));
            chk("stall_ready", 256'(i_ready), 256'(0));
            @(posedge clk); #1;
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk("after_take_valid", 256'(o_valid), 256'(0));
        chk("after_take_ready", 256'(i_ready), 256'(1));
        $display("job N=%0d msg=%02h key=%02h out=%08h lat=%0d stall=%0d", n, m, k, got, lat, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int b;
        int n0;
        int lat;
        logic [BW-1:0] big_n;
        logic [7:0] rn;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o_valid", 256'(o_valid), 256'(0));
        chk("reset_o_out",   256'(o_out), 256'(0));
        chk("reset_i_ready", 256'(i_ready), 256'(0));
        rst = 1'b0;
        #1;
        chk("post_reset_i_ready", 256'(i_ready), 256'(1));

        // Directed jobs with hand-computed results
        do_job(8'h42, 8'h05, 8'd13,  0, 1'b1, 32'h03_42_05_0D);
        do_job(8'h11, 8'h22, 8'd251, 0, 1'b1, 32'h19_11_22_FB);
        do_job(8'h33, 8'h44, 8'd255, 1, 1'b1, 32'h01_33_44_FF);
        do_job(8'h55, 8'h66, 8'd1,   0, 1'b1, 32'h00_55_66_01);
        // Even and zero moduli: only latency and handshake are checked
        do_job(8'hA5, 8'h5A, 8'd10,  0, 1'b0, 32'h0);
        do_job(8'h01, 8'h02, 8'd0,   2, 1'b0, 32'h0);
        // Backpressure
        do_job(8'h42, 8'h05, 8'd13,  5, 1'b1, 32'h03_42_05_0D);

        // Back-to-back with i_valid held high
        @(negedge clk); #1;
        n0 = dut_acc.size();
        i_valid = 1'b1; i_msg = 8'h77; i_key = 8'h03; i_modulus = 8'd97; o_ready = 1'b1;
        @(posedge clk); #1;
        i_msg = 8'h88; i_key = 8'h07; i_modulus = 8'd101;
        b = 0;
        while (dut_acc.size() < n0 + 2 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        i_valid = 1'b0;
        chk("b2b_accepts", 256'(dut_acc.size() - n0), 256'(2));
        if (dut_acc.size() >= n0 + 2)
            chk("b2b_spacing", 256'(dut_acc[n0+1] - dut_acc[n0]), 256'(2*W + 2));
        repeat (LAT + 2) @(posedge clk);
        #1;
        o_ready = 1'b0;
        $display("job back-to-back N=97,101 spacing checked");

        // Reset during CALC
        @(negedge clk); #1;
        i_valid = 1'b1; i_msg = 8'h12; i_key = 8'h34; i_modulus = 8'd13;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_calc_i_ready_low", 256'(i_ready), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_calc_o_valid", 256'(o_valid), 256'(0));
        chk("rst_calc_i_ready", 256'(i_ready), 256'(1));
        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("rst_calc_no_output", 256'(o_valid), 256'(0));
        $display("job reset-in-CALC discarded");

        // Reset during DONE
        @(negedge clk); #1;
        i_valid = 1'b1; i_msg = 8'h9A; i_key = 8'hBC; i_modulus = 8'd251; o_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        b = 0;
        while (!o_valid && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk("done_reached", 256'(o_valid), 256'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_done_o_valid", 256'(o_valid), 256'(0));
        chk("rst_done_i_ready", 256'(i_ready), 256'(1));
        $display("job reset-in-DONE discarded");
        do_job(8'h42, 8'h05, 8'd13, 0, 1'b1, 32'h03_42_05_0D);

        // Random jobs
        for (int j = 0; j < 16; j++) begin
            rn = 8'($urandom_range(1, 255));
            if ((j % 5) != 4) rn = rn | 8'd1;
            do_job(8'($urandom), 8'($urandom), rn, $urandom_range(0, 4), 1'b0, 32'h0);
        end

        // Wide instance: N = 2^256 - 189, so 2^256 = 189 and 2^512 = 189^2 mod N
        big_n = '1;
        big_n = big_n - BW'(188);
        @(negedge clk);
        chk("big_i_ready", 256'(b_i_ready), 256'(1));
        #1;
        b_i_valid = 1'b1; b_msg = BW'(1); b_key = BW'(32'h10001); b_mod = big_n;
        @(posedge clk); #1;
        b_i_valid = 1'b0;
        b_msg = '0; b_key = '0; b_mod = '0;
        lat = 1;
        while (!b_o_valid && lat < 700) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("big_latency", 256'(lat), 256'(2*BW + 1));
        chk("big_base",    b_o_out[4*BW-1:3*BW], 256'd35721);
        chk("big_msg",     b_o_out[3*BW-1:2*BW], 256'd1);
        chk("big_key",     b_o_out[2*BW-1:BW],   256'h10001);
        chk("big_mod",     b_o_out[BW-1:0],      big_n);
        $display("job big N=2^256-189 base=%0d lat=%0d", b_o_out[4*BW-1:3*BW], lat);
        @(posedge clk); #1;
        chk("big_taken", 256'(b_o_valid), 256'(0));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
